// File: rtl/reg_ctrl_pkg.sv
// reg_ctrl_pkg: FunSel opcodes shared by the register bank and its arbiter,
// plus the arbiter state type.
package reg_ctrl_pkg;

  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_LDLO_ZX = 3'b100;
  localparam logic [2:0] FS_LDLO    = 3'b101;
  localparam logic [2:0] FS_LDHI    = 3'b110;
  localparam logic [2:0] FS_LDLO_SX = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker. The first set req bit at
// or above ptr wins, wrapping to bit 0; grant is one-hot, idx its position.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic found;

  // Two passes: positions from ptr upward first, then the wrapped-around ones.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (!found && req[p] && (PW'(p) >= ptr)) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = PW'(p);
      end
    end
    for (int p = 0; p < N; p++) begin
      if (!found && req[p] && (PW'(p) < ptr)) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = PW'(p);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin sharing of one NREG x 16-bit register bank
// between NREQ masters. Define REG_LOCK_EN to add Lock for bounded bursts.
//
// state | meaning
// IDLE  | arbitrate pending requests; outputs quiet
// ISSUE | one granted op on RegE/RegFunSel/RegI with Ack; bank updates at exit
module reg_bank_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int NREG      = 4,
  parameter int SELW      = $clog2(NREG),
  parameter int MAX_BURST = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*3-1:0]    Op,
  input  logic [NREQ*SELW-1:0] Sel,
  input  logic [NREQ*16-1:0]   Data,
`ifdef REG_LOCK_EN
  input  logic [NREQ-1:0]      Lock,
`endif
  output logic [NREQ-1:0]      Ack,
  output logic [NREG-1:0]      RegE,
  output logic [2:0]           RegFunSel,
  output logic [15:0]          RegI,
  output logic                 Busy,
  output logic                 Err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    pick_ptr;
  logic [PW-1:0]    pick_idx;
  logic [NREQ-1:0]  pick_req;
  logic [NREQ-1:0]  grant;
  logic [2:0]       op_w;
  logic [SELW-1:0]  sel_w;
  logic [15:0]      data_w;
  logic [NREG-1:0]  rege_w;
  logic             err_w;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] idx_mask(input logic [PW-1:0] p);
    logic [NREQ-1:0] m;
    m = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (PW'(k) == p) m[k] = 1'b1;
    end
    return m;
  endfunction

`ifdef REG_LOCK_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic          locked;
  logic [BW-1:0] burst;
  logic          lock_release;
  logic          owner_req;
  logic          win_lock;

  assign owner_req = |(Req & idx_mask(ptr));
  assign win_lock  = |(Lock & idx_mask(win));

  // While locked, ptr names the owner; release hands arbitration to the next one.
  always_comb begin
    pick_req     = Req;
    pick_ptr     = ptr;
    lock_release = 1'b0;
    if (locked) begin
      if ((burst >= BW'(MAX_BURST)) || !owner_req) begin
        lock_release = 1'b1;
        pick_ptr     = ptr_next(ptr);
      end else begin
        pick_req = Req & idx_mask(ptr);
      end
    end
  end
`else
  assign pick_req = Req;
  assign pick_ptr = ptr;
`endif

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (grant),
    .idx   (pick_idx)
  );

  always_comb begin
    op_w   = '0;
    sel_w  = '0;
    data_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        op_w   = Op[k*3 +: 3];
        sel_w  = Sel[k*SELW +: SELW];
        data_w = Data[k*16 +: 16];
      end
    end
  end

  // An out-of-range index leaves every enable low and raises Err instead.
  always_comb begin
    rege_w = '0;
    for (int i = 0; i < NREG; i++) begin
      rege_w[i] = (sel_w == SELW'(i));
    end
    err_w = ({1'b0, sel_w} >= (SELW + 1)'(NREG));
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      Ack       <= '0;
      RegE      <= '0;
      RegFunSel <= FS_DEC;
      RegI      <= '0;
      Busy      <= 1'b0;
      Err       <= 1'b0;
`ifdef REG_LOCK_EN
      locked    <= 1'b0;
      burst     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef REG_LOCK_EN
          if (lock_release) begin
            locked <= 1'b0;
            burst  <= '0;
            ptr    <= pick_ptr;
          end
`endif
          if (|grant) begin
            state     <= ISSUE;
            win       <= pick_idx;
            Ack       <= grant;
            RegE      <= rege_w;
            RegFunSel <= op_w;
            RegI      <= data_w;
            Busy      <= 1'b1;
            Err       <= err_w;
          end
        end
        ISSUE: begin
          state <= IDLE;
          Ack   <= '0;
          RegE  <= '0;
          Busy  <= 1'b0;
          Err   <= 1'b0;
`ifdef REG_LOCK_EN
          if (win_lock) begin
            ptr    <= win;
            locked <= 1'b1;
            burst  <= burst + 1'b1;
          end else begin
            ptr    <= ptr_next(win);
            locked <= 1'b0;
            burst  <= '0;
          end
`else
          ptr <= ptr_next(win);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
